// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the floating-point normalize/round stage.
//   - IEEE-754 single exponent constants (bias, all-ones exponent)
//   - Bit positions inside the 28-bit extended mantissa
//       [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S
//   - Width of the internal signed exponent (two extra bits so that
//     overflow and underflow never wrap)
//   - FSM state encoding and packed constants for infinity / zero
// ---------------------------------------------------------------------------
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MANT_W = 28;
  localparam int XEXP_W = FP_EXP_W + 2;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX = 2 * EXP_BIAS + 1;  // 255, reserved for Inf/NaN

  // Extended mantissa bit positions
  localparam int BIT_CARRY = 27;
  localparam int BIT_HIDDEN = 26;
  localparam int FRAC_HI = 25;
  localparam int FRAC_LO = 3;
  localparam int BIT_G = 2;
  localparam int BIT_R = 1;
  localparam int BIT_S = 0;

  // Signed constants for the internal exponent arithmetic
  localparam logic signed [XEXP_W-1:0] XEXP_ONE = XEXP_W'(1);
  localparam logic signed [XEXP_W-1:0] XEXP_MAX = XEXP_W'(EXP_MAX);

  // Packed result constants (magnitude only for infinity; sign is prepended)
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// ---------------------------------------------------------------------------
// fp_round_rne
// Combinational round-to-nearest-even for a normalized extended mantissa.
// Ports:
//   mant_i     [26:0]  normalized mantissa (hidden bit at [26]) with G/R/S
//   exp_i      signed  internal exponent before rounding
//   frac_o     [22:0]  rounded fraction field
//   exp_o      [7:0]   exponent field after a possible rounding carry
//   overflow_o         rounded exponent reaches or exceeds 255
// ---------------------------------------------------------------------------
module fp_round_rne
  import fp_pkg::*;
(
  input  logic        [BIT_HIDDEN:0] mant_i,
  input  logic signed [XEXP_W-1:0]   exp_i,
  output logic        [22:0]         frac_o,
  output logic        [FP_EXP_W-1:0] exp_o,
  output logic                       overflow_o
);

  logic                     round_up;
  logic        [24:0]       sum;
  logic signed [XEXP_W-1:0] exp_adj;

  // Round up when above half, or exactly half and the kept LSB is odd.
  assign round_up = mant_i[BIT_G] & (mant_i[BIT_R] | mant_i[BIT_S] | mant_i[FRAC_LO]);

  assign sum = {1'b0, mant_i[BIT_HIDDEN:FRAC_LO]} + {24'b0, round_up};

  // A carry out of the hidden bit means the mantissa became 10.000...;
  // renormalize by one position, which leaves an all-zero fraction.
  assign exp_adj    = exp_i + {{(XEXP_W-1){1'b0}}, sum[24]};
  assign frac_o     = sum[24] ? sum[23:1] : sum[22:0];
  assign exp_o      = exp_adj[FP_EXP_W-1:0];
  assign overflow_o = (exp_adj >= XEXP_MAX);

endmodule

// File: rtl/fp_normalize_round.sv
// ---------------------------------------------------------------------------
// fp_normalize_round
// Post-add stage: normalizes a raw extended-mantissa sum one bit per cycle,
// rounds to nearest-even, detects overflow/underflow and presents a packed
// IEEE-754 single over a valid/ready handshake. One operation in flight.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   raw sum handshake (in_ready high only in IDLE)
//   in_sign, in_exp       sign and biased exponent of the raw sum
//   in_mant               extended mantissa: carry, hidden, fraction, G, R, S
//   out_valid / out_ready result handshake
//   result                packed single-precision result
//   overflow, underflow   saturated-to-infinity / flushed-to-zero flags
// ---------------------------------------------------------------------------
module fp_normalize_round
  import fp_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow
);

  state_t                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic signed [XEXP_W-1:0] exp_q, exp_d;
  logic        [MANT_W-1:0] mant_q, mant_d;
  logic                     special_q, special_d;
  logic        [31:0]       result_q, result_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;

  logic        [22:0]       rnd_frac;
  logic        [EXP_W-1:0]  rnd_exp;
  logic                     rnd_ovf;

  fp_round_rne u_round (
    .mant_i     (mant_q[BIT_HIDDEN:0]),
    .exp_i      (exp_q),
    .frac_o     (rnd_frac),
    .exp_o      (rnd_exp),
    .overflow_o (rnd_ovf)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      special_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      special_q <= special_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    special_d = special_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = XEXP_W'(in_exp);
          mant_d = in_mant;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          if (&in_exp) begin
            // NaN/Inf pass straight through. Routing it via ROUND (which
            // skips rounding for special operands) gives a two-cycle latency.
            result_d  = {in_sign, {EXP_W{1'b1}}, in_mant[FRAC_HI:FRAC_LO]};
            special_d = 1'b1;
            state_d   = ST_ROUND;
          end else begin
            special_d = 1'b0;
            state_d   = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        if (mant_q == '0) begin
          result_d = POS_ZERO;
          state_d  = ST_DONE;
        end else if (mant_q[BIT_CARRY]) begin
          // Right shift by one; the bit leaving R is folded into sticky.
          mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[BIT_R] | mant_q[BIT_S]};
          exp_d   = exp_q + XEXP_ONE;
          state_d = ST_ROUND;
        end else if (mant_q[BIT_HIDDEN]) begin
          state_d = ST_ROUND;
        end else if (exp_q <= XEXP_ONE) begin
          // No room for another left shift: flush to signed zero.
          result_d = {sign_q, 31'b0};
          unf_d    = 1'b1;
          state_d  = ST_DONE;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - XEXP_ONE;
        end
      end

      ST_ROUND: begin
        if (!special_q) begin
          if (rnd_ovf) begin
            result_d = {sign_q, INF_MAG};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, rnd_exp, rnd_frac};
          end
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    result    = result_q;
    overflow  = ovf_q;
    underflow = unf_q;
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// ---------------------------------------------------------------------------
// tb_fp_normalize_round
// Directed-vector bench for fp_normalize_round. Expected results and
// latencies are hand-computed from the IEEE-754 single format.
// Latency is counted in rising edges, the accepting edge being edge 1.
// ---------------------------------------------------------------------------
module tb_fp_normalize_round;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  fp_normalize_round dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Present a raw sum in IDLE and let it be accepted on the next edge.
  task automatic start_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [27:0] m);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and check the latency.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_res(input string tag, input logic [31:0] r,
                           input logic ovf, input logic unf);
    chk({tag, "_result"}, result, r);
    chk({tag, "_overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, "_underflow"}, 32'(underflow), 32'(unf));
    $display("op %-10s result=%h ovf=%0b unf=%0b", tag, result, overflow, underflow);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_release"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [27:0] m, input logic [31:0] r,
                        input logic ovf, input logic unf, input int lat);
    start_op(tag, s, e, m);
    wait_done(tag, lat);
    check_res(tag, r, ovf, unf);
    release_out(tag);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {30'b0, overflow, underflow}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Normalization, rounding and special cases
    run_op("carry",     1'b0, 8'h7E, 28'h8000000, 32'h3F800000, 1'b0, 1'b0, 3);
    run_op("negcarry",  1'b1, 8'h7E, 28'hC000000, 32'hBFC00000, 1'b0, 1'b0, 3);
    run_op("cancel",    1'b0, 8'h7E, 28'h0800000, 32'h3D800000, 1'b0, 1'b0, 6);
    run_op("tie_odd",   1'b0, 8'h7F, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 3);
    run_op("tie_even",  1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 3);
    run_op("zero",      1'b1, 8'h7F, 28'h0000000, 32'h00000000, 1'b0, 1'b0, 2);
    run_op("rnd_r",     1'b0, 8'h7F, 28'h4000006, 32'h3F800001, 1'b0, 1'b0, 3);
    run_op("rnd_carry", 1'b0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, 3);
    run_op("rsh_rnd",   1'b0, 8'h7E, 28'h8000018, 32'h3F800002, 1'b0, 1'b0, 3);
    run_op("unf",       1'b0, 8'h01, 28'h2000000, 32'h00000000, 1'b0, 1'b1, 2);
    run_op("unf_neg",   1'b1, 8'h01, 28'h2000000, 32'h80000000, 1'b0, 1'b1, 2);
    run_op("unf_shift", 1'b0, 8'h03, 28'h0800000, 32'h00000000, 1'b0, 1'b1, 4);
    run_op("nan",       1'b0, 8'hFF, 28'h0400008, 32'h7F880001, 1'b0, 1'b0, 2);
    run_op("ninf",      1'b1, 8'hFF, 28'h4000000, 32'hFF800000, 1'b0, 1'b0, 2);
    run_op("ovf_rnd",   1'b0, 8'hFE, 28'h7FFFFFC, 32'h7F800000, 1'b1, 1'b0, 3);
    run_op("ovf",       1'b0, 8'hFE, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 3);

    // Backpressure: DONE held for 5 cycles with out_ready low
    start_op("bp", 1'b0, 8'h7E, 28'h8000000);
    wait_done("bp", 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_result", result, 32'h3F800000);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
    end
    check_res("bp", 32'h3F800000, 1'b0, 1'b0);

    // out_ready together with a new in_valid in DONE: accepted only from IDLE
    in_sign   = 1'b1;
    in_exp    = 8'h7E;
    in_mant   = 28'hC000000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("ovl_out_valid", 32'(out_valid), 32'd0);
    chk("ovl_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done("ovl", 3);
    check_res("ovl", 32'hBFC00000, 1'b0, 1'b0);
    release_out("ovl");

    // Leave a non-zero result with a flag set, then reset mid-SHIFT
    run_op("ovf2",      1'b1, 8'hFE, 28'h8000000, 32'hFF800000, 1'b1, 1'b0, 3);
    start_op("midrst", 1'b0, 8'h7E, 28'h0000010);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_flags", {30'b0, overflow, underflow}, 32'h0);
    $display("op %-10s in_ready=%0b out_valid=%0b result=%h", "midrst", in_ready, out_valid, result);

    // Operation after the mid-flight reset
    run_op("post_rst",  1'b0, 8'h7E, 28'h8000000, 32'h3F800000, 1'b0, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
